router_1xn: RTL and testbench
=============================

Name: router_1xn

Overview:
- Parametrised successor to the 1x1 router: one byte-serial input, NUM_PORTS outputs.
- Store-and-forward: buffers a framed packet, checks an XOR checksum, then forwards header+payload to the output port selected by the header.
- Malformed or disallowed packets are dropped and flagged.
- A register interface (wr/rd/addr) holds a port-enable mask and statistics counters.

Parameters:
- WIDTH, 8, data word width (min 8)
- NUM_PORTS, 4, number of output ports (2..16)
- DEPTH, 16, packet buffer words (header+payload), power of 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dut_inp  in  WIDTH  input data word
- inp_valid  in  1  high for every word of a packet; low for at least one cycle between packets
- dut_outp  out  NUM_PORTS*WIDTH  output data; port p on bits [p*WIDTH +: WIDTH]
- outp_valid  out  NUM_PORTS  per-port word valid
- busy  out  1  router cannot accept input
- error  out  1  one-cycle pulse on packet drop or input-while-busy
- wr  in  1  register write strobe
- rd  in  1  register read strobe
- addr  in  3  register address
- wdata  in  16  register write data
- rdata  out  16  register read data

Behaviour:
- Packet framing:
  - Contiguous inp_valid run: word0 = header, words 1..n-2 = payload, word n-1 = checksum.
  - Checksum = XOR of all preceding words in the packet.
  - dest = header[clog2(NUM_PORTS)-1:0]; remaining header bits are opaque.
- States: IDLE, RECV, CHECK, SEND, DROP.
  - IDLE: inp_valid=1 -> store word at buffer[0], go RECV, running XOR = word.
  - RECV: each inp_valid=1 word is written at wptr and XORed in.
    - First cycle with inp_valid=0 -> CHECK.
    - Stored words include the checksum word; it is excluded from forwarding.
  - CHECK (exactly 1 cycle): drop if any of:
    - total words < 3
    - word count > DEPTH+1 (overflow; excess words discarded)
    - final XOR != 0
    - dest >= NUM_PORTS
    - PORT_EN[dest]=0
  - On drop: error pulses this cycle, go DROP. Otherwise go SEND.
  - SEND: outputs the n-1 stored words (header+payload) on port dest, one per cycle, outp_valid[dest]=1 contiguously. Other ports stay at outp_valid=0, data 0. After the last word -> IDLE.
  - DROP (1 cycle): clear pointers -> IDLE.
- busy = 1 in CHECK, SEND and DROP; 0 in IDLE and RECV.
  - inp_valid=1 while busy: word discarded, error pulses, DROP_CNT increments.
- Latency: let k be the first cycle with inp_valid=0 after a packet.
  - CHECK occupies cycle k+1.
  - The header appears registered on dut_outp with outp_valid high in cycle k+2.
  - The last payload word appears in cycle k+n.
- Registers:
  - rdata is registered; it updates the cycle after rd=1 and holds otherwise.
  - Unmapped addresses read 0.
  - 0 PORT_EN[NUM_PORTS-1:0], R/W, reset all ones.
  - 1 RX_CNT, packets fully received.
  - 2 TX_CNT, packets forwarded; increments in the cycle SEND exits.
  - 3 DROP_CNT.
  - 4 STATUS, read-only: [2:0] last drop reason (1 short, 2 overflow, 3 checksum, 4 bad dest, 5 disabled, 6 input-while-busy), [3] busy.
  - Counters are 16-bit and saturate at 0xFFFF. Any write to 1..3 clears that counter; on a same-cycle clear and increment, clear wins.
  - PORT_EN changes take effect at the next CHECK; a packet already in SEND completes.
  - wr and rd in the same cycle: the write is applied and rdata returns the pre-write value.
- Reset: state IDLE; outp_valid=0; dut_outp=0; busy=0; error=0; rdata=0; counters 0; PORT_EN all ones.
  - A partial or in-flight packet is discarded with no output.

Test Plan:
- Good packet (NUM_PORTS=4): send A2,11,22,33,A2^11^22^33 -> port 2 outputs A2,11,22,33 in cycles k+2..k+5; outp_valid=0100; RX_CNT=1, TX_CNT=1.
- Bad checksum: A1,55,00 -> no outp_valid; error pulse at k+1; DROP_CNT=1; STATUS[2:0]=3.
- Short and overflow: 2-word packet -> reason 1. With DEPTH=16, an 18-word packet -> reason 2. Next valid packet forwards correctly.
- Disabled port: write PORT_EN=0xD, send a valid packet to dest 1 -> dropped with reason 5. Re-enable port 1 -> same packet forwarded.
- Input while busy: assert inp_valid during SEND -> error pulse, STATUS=6, current output unaffected. Reset mid-SEND -> outp_valid=0 next cycle and all registers at reset values.
- Counter write: write addr1 in the same cycle RX_CNT would increment -> RX_CNT reads 0. rd with addr=7 -> rdata=0 next cycle.

Source files
------------

// File: rtl/router_1xn.sv
// Store-and-forward 1xN packet router: buffers a framed packet, verifies its XOR
// checksum and forwards header+payload to the port named by the header.
module router_1xn #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           dut_inp,
  input  logic                       inp_valid,
  output logic [NUM_PORTS*WIDTH-1:0] dut_outp,
  output logic [NUM_PORTS-1:0]       outp_valid,
  output logic                       busy,
  output logic                       error,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [2:0]                 addr,
  input  logic [15:0]                wdata,
  output logic [15:0]                rdata
);

  localparam int unsigned DW = $clog2(NUM_PORTS);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 2) + 1;

  localparam logic [CW-1:0] C_MIN   = CW'(3);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_MAXOK = CW'(DEPTH + 1);
  localparam logic [CW-1:0] C_SAT   = CW'(DEPTH + 2);

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_SHORT = 3'd1;
  localparam logic [2:0] R_OVF   = 3'd2;
  localparam logic [2:0] R_CKS   = 3'd3;
  localparam logic [2:0] R_DEST  = 3'd4;
  localparam logic [2:0] R_DIS   = 3'd5;
  localparam logic [2:0] R_BUSY  = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_SEND, S_DROP} state_t;

  state_t                     state_q, state_n;
  logic [CW-1:0]              cnt_q, cnt_n;
  logic [CW-1:0]              rptr_q, rptr_n;
  logic [WIDTH-1:0]           xor_q, xor_n;
  logic [DW-1:0]              dest_q, dest_n;
  logic                       drop_q, drop_n;
  logic [2:0]                 reason_q, reason_n;
  logic [NUM_PORTS*WIDTH-1:0] outp_q, outp_n;
  logic [NUM_PORTS-1:0]       valid_q, valid_n;
  logic                       busy_q, busy_n;
  logic                       error_q, error_n;
  logic [15:0]                rdata_q, rdata_n;
  logic [NUM_PORTS-1:0]       port_en_q, port_en_n;
  logic [15:0]                rx_q, rx_n, tx_q, tx_n, drp_q, drp_n;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic             send_en;
  logic [WIDTH-1:0] send_word;
  logic             rx_inc, tx_inc, drp_inc;
  logic [2:0]       chk_reason;
  logic [DW-1:0]    hdr_dest;
  logic [15:0]      reg_mux;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  // Packet buffer; data only, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= dut_inp;
  end

  // Drop reason for the packet just received, in priority order.
  always_comb begin
    hdr_dest = mem[0][DW-1:0];
    if (cnt_q < C_MIN)                   chk_reason = R_SHORT;
    else if (cnt_q > C_MAXOK)            chk_reason = R_OVF;
    else if (xor_q != '0)                chk_reason = R_CKS;
    else if (32'(hdr_dest) >= NUM_PORTS) chk_reason = R_DEST;
    else if (!port_en_q[hdr_dest])       chk_reason = R_DIS;
    else                                 chk_reason = R_NONE;
  end

  always_comb begin
    case (addr)
      3'd0:    reg_mux = 16'(port_en_q);
      3'd1:    reg_mux = rx_q;
      3'd2:    reg_mux = tx_q;
      3'd3:    reg_mux = drp_q;
      3'd4:    reg_mux = {12'd0, busy_q, reason_q};
      default: reg_mux = 16'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    rptr_n    = rptr_q;
    xor_n     = xor_q;
    dest_n    = dest_q;
    drop_n    = drop_q;
    reason_n  = reason_q;
    outp_n    = '0;
    valid_n   = '0;
    error_n   = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    send_en   = 1'b0;
    send_word = '0;
    rx_inc    = 1'b0;
    tx_inc    = 1'b0;
    drp_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_n  = '0;
        rptr_n = '0;
        if (inp_valid) begin
          we      = 1'b1;
          cnt_n   = CW'(1);
          xor_n   = dut_inp;
          state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (inp_valid) begin
          if (cnt_q < C_DEPTH) begin
            we    = 1'b1;
            waddr = cnt_q[AW-1:0];
          end
          if (cnt_q < C_SAT) cnt_n = cnt_q + CW'(1);
          xor_n = xor_q ^ dut_inp;
        end else begin
          state_n = S_CHECK;
          rx_inc  = 1'b1;
          dest_n  = hdr_dest;
          drop_n  = (chk_reason != R_NONE);
          if (chk_reason != R_NONE) begin
            error_n  = 1'b1;
            drp_inc  = 1'b1;
            reason_n = chk_reason;
          end
        end
      end
      S_CHECK: begin
        if (drop_q) begin
          state_n = S_DROP;
        end else begin
          state_n   = S_SEND;
          send_en   = 1'b1;
          send_word = mem[0];
          rptr_n    = CW'(1);
        end
      end
      S_SEND: begin
        // Stored checksum word sits at cnt-1 and is never forwarded.
        if (rptr_q < cnt_q - CW'(1)) begin
          send_en   = 1'b1;
          send_word = mem[rptr_q[AW-1:0]];
          rptr_n    = rptr_q + CW'(1);
        end else begin
          state_n = S_IDLE;
          tx_inc  = 1'b1;
          cnt_n   = '0;
          rptr_n  = '0;
        end
      end
      S_DROP: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        rptr_n  = '0;
      end
      default: state_n = S_IDLE;
    endcase

    if (inp_valid && (state_q inside {S_CHECK, S_SEND, S_DROP})) begin
      error_n  = 1'b1;
      drp_inc  = 1'b1;
      reason_n = R_BUSY;
    end

    if (send_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (dest_q == DW'(p)) begin
          outp_n[p*WIDTH +: WIDTH] = send_word;
          valid_n[p]               = 1'b1;
        end
      end
    end

    busy_n = (state_n inside {S_CHECK, S_SEND, S_DROP});

    // Register file: a clear on write beats a same-cycle increment.
    port_en_n = (wr && addr == 3'd0) ? wdata[NUM_PORTS-1:0] : port_en_q;
    rx_n  = (wr && addr == 3'd1) ? 16'd0 : ((rx_inc  && rx_q  != 16'hFFFF) ? rx_q  + 16'd1 : rx_q);
    tx_n  = (wr && addr == 3'd2) ? 16'd0 : ((tx_inc  && tx_q  != 16'hFFFF) ? tx_q  + 16'd1 : tx_q);
    drp_n = (wr && addr == 3'd3) ? 16'd0 : ((drp_inc && drp_q != 16'hFFFF) ? drp_q + 16'd1 : drp_q);
    rdata_n = rd ? reg_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rptr_q    <= '0;
      xor_q     <= '0;
      dest_q    <= '0;
      drop_q    <= 1'b0;
      reason_q  <= R_NONE;
      outp_q    <= '0;
      valid_q   <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      port_en_q <= '1;
      rx_q      <= '0;
      tx_q      <= '0;
      drp_q     <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rptr_q    <= rptr_n;
      xor_q     <= xor_n;
      dest_q    <= dest_n;
      drop_q    <= drop_n;
      reason_q  <= reason_n;
      outp_q    <= outp_n;
      valid_q   <= valid_n;
      busy_q    <= busy_n;
      error_q   <= error_n;
      rdata_q   <= rdata_n;
      port_en_q <= port_en_n;
      rx_q      <= rx_n;
      tx_q      <= tx_n;
      drp_q     <= drp_n;
    end
  end

  assign dut_outp   = outp_q;
  assign outp_valid = valid_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: packet table plus hand sequences, scoreboard on outputs.
module tb_router_1xn;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dut_inp;
  logic        inp_valid;
  logic [31:0] dut_outp;
  logic [3:0]  outp_valid;
  logic        busy, error;
  logic        wr, rd;
  logic [2:0]  addr;
  logic [15:0] wdata, rdata;

  router_1xn #(.WIDTH(8), .NUM_PORTS(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .dut_inp(dut_inp), .inp_valid(inp_valid),
    .dut_outp(dut_outp), .outp_valid(outp_valid), .busy(busy), .error(error),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] hdr;
    int         n;
    bit         bad;
    int         reason;
  } vec_t;

  exp_t       q[$];
  logic [7:0] pkt[$];
  vec_t       tbl[9];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         exp_tx = 0;
  int         exp_drop = 0;
  logic [15:0] v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output scoreboard: each valid beat must match the oldest expected word.
  always @(negedge clk) begin
    if (outp_valid != 4'd0) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(outp_valid), 32'd0);
      end else begin
        exp_t e;
        logic [31:0] eo;
        e  = q.pop_front();
        eo = '0;
        eo[e.port*8 +: 8] = e.data;
        chk("outp_valid", 32'(outp_valid), 32'(1) << e.port);
        chk("dut_outp", dut_outp, eo);
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void build_pkt(input logic [7:0] hdr, input int n, input bit badck);
    logic [7:0] x, w;
    pkt.delete();
    x = 8'h00;
    if (n == 1) begin
      pkt.push_back(hdr);
      return;
    end
    for (int i = 0; i < n - 1; i++) begin
      w = (i == 0) ? hdr : hdr + 8'(i * 37);
      pkt.push_back(w);
      x = x ^ w;
    end
    pkt.push_back(badck ? (x ^ 8'h5A) : x);
  endfunction

  // Drives pkt starting at a negedge; returns at the negedge of cycle k+1.
  task automatic send_pkt(input int reason, input bit clr_rx);
    int n, k;
    n = pkt.size();
    k = cyc + n;
    if (reason == 0) begin
      for (int i = 0; i < n - 1; i++) q.push_back('{port: int'(pkt[0][1:0]), data: pkt[i], cyc: k + 2 + i});
      exp_tx++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < n; i++) begin
      inp_valid = 1'b1;
      dut_inp   = pkt[i];
      @(negedge clk);
    end
    inp_valid = 1'b0;
    dut_inp   = 8'h00;
    if (clr_rx) begin
      wr = 1'b1; addr = 3'd1; wdata = 16'h0000;
    end
    @(negedge clk);
    wr = 1'b0;
    chk("error_at_check", 32'(error), 32'(reason != 0));
    chk("busy_at_check", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (busy == 1'b0 && q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 200) chk("wait_idle_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] val);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    val = rdata;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{hdr: 8'h40, n: 5,  bad: 1'b0, reason: 0};
    tbl[1] = '{hdr: 8'h5D, n: 7,  bad: 1'b0, reason: 0};
    tbl[2] = '{hdr: 8'h07, n: 3,  bad: 1'b0, reason: 0};
    tbl[3] = '{hdr: 8'h12, n: 2,  bad: 1'b0, reason: 1};
    tbl[4] = '{hdr: 8'h01, n: 1,  bad: 1'b0, reason: 1};
    tbl[5] = '{hdr: 8'h33, n: 17, bad: 1'b0, reason: 0};
    tbl[6] = '{hdr: 8'h6E, n: 18, bad: 1'b0, reason: 2};
    tbl[7] = '{hdr: 8'h8C, n: 4,  bad: 1'b1, reason: 3};
    tbl[8] = '{hdr: 8'h6E, n: 4,  bad: 1'b0, reason: 0};

    reset = 1'b1; inp_valid = 1'b0; dut_inp = 8'h00;
    wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_outp_valid", 32'(outp_valid), 32'd0);
    chk("rst_dut_outp", dut_outp, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    read_reg(3'd0, v); chk("rst_port_en", 32'(v), 32'h000F);

    // Good packet to port 2.
    pkt.delete();
    pkt.push_back(8'hA2); pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    pkt.push_back(8'hA2 ^ 8'h11 ^ 8'h22 ^ 8'h33);
    send_pkt(0, 1'b0);
    wait_idle();
    read_reg(3'd1, v); chk("rx_cnt_good", 32'(v), 32'd1);
    read_reg(3'd2, v); chk("tx_cnt_good", 32'(v), 32'd1);

    // Bad checksum.
    pkt.delete();
    pkt.push_back(8'hA1); pkt.push_back(8'h55); pkt.push_back(8'h00);
    send_pkt(3, 1'b0);
    wait_idle();
    read_reg(3'd3, v); chk("drop_cnt_cks", 32'(v), 32'd1);
    read_reg(3'd4, v); chk("status_cks", 32'(v), 32'd3);

    foreach (tbl[i]) begin
      build_pkt(tbl[i].hdr, tbl[i].n, tbl[i].bad);
      send_pkt(tbl[i].reason, 1'b0);
      wait_idle();
      if (tbl[i].reason != 0) begin
        read_reg(3'd4, v);
        chk($sformatf("tbl%0d_status", i), 32'(v), 32'(tbl[i].reason));
      end
    end
    read_reg(3'd2, v); chk("tx_after_table", 32'(v), 32'(exp_tx));
    read_reg(3'd3, v); chk("drop_after_table", 32'(v), 32'(exp_drop));

    // Disabled port, then re-enabled.
    write_reg(3'd0, 16'h000D);
    build_pkt(8'h15, 5, 1'b0);
    send_pkt(5, 1'b0);
    wait_idle();
    read_reg(3'd4, v); chk("status_disabled", 32'(v), 32'd5);
    write_reg(3'd0, 16'h000F);
    send_pkt(0, 1'b0);
    wait_idle();

    // Input while busy during SEND.
    build_pkt(8'h24, 7, 1'b0);
    send_pkt(0, 1'b0);
    @(negedge clk);
    inp_valid = 1'b1; dut_inp = 8'hEE;
    @(negedge clk);
    inp_valid = 1'b0; dut_inp = 8'h00;
    chk("error_busy_input", 32'(error), 32'd1);
    exp_drop++;
    wait_idle();
    read_reg(3'd4, v); chk("status_busy", 32'(v), 32'd6);
    read_reg(3'd3, v); chk("drop_total", 32'(v), 32'(exp_drop));
    read_reg(3'd2, v); chk("tx_total", 32'(v), 32'(exp_tx));

    // Same-cycle write and read returns the old value.
    wr = 1'b1; rd = 1'b1; addr = 3'd0; wdata = 16'h0003;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("wr_rd_old", 32'(rdata), 32'h000F);
    read_reg(3'd0, v); chk("wr_rd_new", 32'(v), 32'h0003);
    write_reg(3'd0, 16'h000F);

    // RX_CNT clear in the cycle it would increment.
    build_pkt(8'h39, 4, 1'b0);
    send_pkt(0, 1'b1);
    wait_idle();
    read_reg(3'd1, v); chk("rx_clear_wins", 32'(v), 32'd0);
    read_reg(3'd2, v); chk("tx_before_unmapped", 32'(v), 32'(exp_tx));
    read_reg(3'd7, v); chk("unmapped_read", 32'(v), 32'd0);

    // Reset in the middle of SEND.
    write_reg(3'd0, 16'h000E);
    build_pkt(8'h4B, 8, 1'b0);
    send_pkt(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outp_valid", 32'(outp_valid), 32'd0);
    chk("midrst_dut_outp", dut_outp, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_left", 32'(q.size()), 32'd5);
    q.delete();
    reset = 1'b0;
    exp_tx = 0; exp_drop = 0;
    read_reg(3'd0, v); chk("midrst_port_en", 32'(v), 32'h000F);
    read_reg(3'd1, v); chk("midrst_rx", 32'(v), 32'd0);
    read_reg(3'd2, v); chk("midrst_tx", 32'(v), 32'd0);
    read_reg(3'd3, v); chk("midrst_drop", 32'(v), 32'd0);
    read_reg(3'd4, v); chk("midrst_status", 32'(v), 32'd0);

    // Router still forwards after reset.
    build_pkt(8'h4C, 6, 1'b0);
    send_pkt(0, 1'b0);
    wait_idle();
    read_reg(3'd2, v); chk("tx_post_reset", 32'(v), 32'(exp_tx));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
